// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg
// Shared constants for the scoreboarded register file. These carry the same
// names as the original defines header so existing pipeline code reads the
// same; PendBus gives the pending-counter width.
// No ports (package).

package regfile_sb_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int RegNumLog2 = 5;
    localparam int RegNum     = 32;
    localparam int PendBus    = 2;

    localparam logic RstEnable   = 1'b1;
    localparam logic WriteEnable = 1'b1;
    localparam logic ReadEnable  = 1'b1;

    localparam logic [RegBus-1:0] ZeroWord = '0;

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if
// Bundles the read, write, reservation and flush signals of the register file.
//   master : issue / write-back side (drives we/waddr/wdata/re/raddr/rsv_*/flush)
//   slave  : the register file (drives rdata/rbusy/rsv_ok/wr_conflict)
// Port k of a flattened bus sits at [k*W +: W].

interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);

    logic [NUM_WR-1:0]        we;
    logic [NUM_WR*ADDR_W-1:0] waddr;
    logic [NUM_WR*DATA_W-1:0] wdata;
    logic [NUM_RD-1:0]        re;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rbusy;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic                     rsv_ok;
    logic                     flush;
    logic                     wr_conflict;

    modport master (
        output we, waddr, wdata, re, raddr, rsv_en, rsv_addr, flush,
        input  rdata, rbusy, rsv_ok, wr_conflict
    );

    modport slave (
        input  we, waddr, wdata, re, raddr, rsv_en, rsv_addr, flush,
        output rdata, rbusy, rsv_ok, wr_conflict
    );

endinterface

// File: rtl/regfile_sb_cnt.sv
// regfile_sb_cnt
// Pending-write counter for one register.
//   clk, rst : clock, async active-high reset
//   inc      : accepted reservation for this register
//   hit      : at least one enabled write targets this register this cycle
//   flush    : synchronous clear, overrides inc/hit
//   cnt      : current number of in-flight writes
//   full     : counter at its maximum; further reservations must be refused

module regfile_sb_cnt
    import regfile_sb_pkg::*;
#(
    parameter int PEND_W = PendBus
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              hit,
    input  logic              flush,
    output logic [PEND_W-1:0] cnt,
    output logic              full
);

    localparam logic [PEND_W-1:0] CntMax = '1;

    // A reservation and a write-back in the same cycle cancel out. A write
    // with nothing pending floors at zero, which also covers write-backs of
    // instructions issued before a reset or flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (inc && !hit) begin
            cnt <= cnt + 1'b1;
        end else if (hit && !inc && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign full = (cnt == CntMax);

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb
// Multi-port register file with write-through bypass and a per-register
// in-flight write scoreboard.
//   clk, rst : clock, async active-high reset
//   bus      : regfile_sb_if slave modport
//              we/waddr/wdata  NUM_WR write ports, highest index wins
//              re/raddr/rdata  NUM_RD combinational read ports
//              rbusy           operand still awaiting write-back
//              rsv_en/rsv_addr/rsv_ok  destination reservation at issue
//              flush           clear all pending counters
//              wr_conflict     registered, two write ports hit one address
// Register 0 is hard-wired zero and never tracked.

module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int ADDR_W = RegAddrBus,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int PEND_W = PendBus,
    parameter int BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [PEND_W-1:0] cnt  [NREG];
    logic              full [NREG];
    logic [NREG-1:0]   whit;
    logic              rsv_ok;
    logic              conflict_now;
    logic              wr_conflict_q;

    // Which registers receive at least one write this cycle; several ports
    // hitting one register still count as a single hit.
    always_comb begin
        whit = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (bus.we[k] == WriteEnable &&
                bus.waddr[k*ADDR_W +: ADDR_W] != '0) begin
                whit[bus.waddr[k*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
    end

    // Any pair of enabled ports aimed at the same non-zero register.
    always_comb begin
        conflict_now = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (bus.we[i] && bus.we[j] &&
                    bus.waddr[i*ADDR_W +: ADDR_W] != '0 &&
                    bus.waddr[i*ADDR_W +: ADDR_W] == bus.waddr[j*ADDR_W +: ADDR_W]) begin
                    conflict_now = 1'b1;
                end
            end
        end
    end

    // A full counter can still accept a reservation when a write-back to the
    // same register lands this cycle, since the two cancel.
    assign rsv_ok = (rst != RstEnable) && !bus.flush && bus.rsv_en &&
                    (bus.rsv_addr != '0) &&
                    (!full[bus.rsv_addr] || whit[bus.rsv_addr]);

    assign bus.rsv_ok      = rsv_ok;
    assign bus.wr_conflict = wr_conflict_q;

    // Ports are visited in ascending order so the highest index wins on a
    // shared address. Register 0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (bus.we[k] == WriteEnable &&
                    bus.waddr[k*ADDR_W +: ADDR_W] != '0) begin
                    regs[bus.waddr[k*ADDR_W +: ADDR_W]] <= bus.wdata[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            wr_conflict_q <= 1'b0;
        end else begin
            wr_conflict_q <= conflict_now;
        end
    end

    assign cnt[0]  = '0;
    assign full[0] = 1'b1;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        regfile_sb_cnt #(
            .PEND_W (PEND_W)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (rsv_ok && (bus.rsv_addr == ADDR_W'(r))),
            .hit   (whit[r]),
            .flush (bus.flush),
            .cnt   (cnt[r]),
            .full  (full[r])
        );
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              busy;

        assign ra = bus.raddr[i*ADDR_W +: ADDR_W];

        // Forwarded data takes the highest matching write port. The last
        // outstanding write landing this cycle makes the operand available
        // now, so busy is dropped in that case when bypassing.
        always_comb begin
            rd   = '0;
            busy = 1'b0;
            if (rst != RstEnable && bus.re[i] == ReadEnable && ra != '0) begin
                rd = regs[ra];
                if (BYPASS != 0) begin
                    for (int k = 0; k < NUM_WR; k++) begin
                        if (bus.we[k] && bus.waddr[k*ADDR_W +: ADDR_W] == ra) begin
                            rd = bus.wdata[k*DATA_W +: DATA_W];
                        end
                    end
                end
                busy = (cnt[ra] != '0) &&
                       !((BYPASS != 0) && cnt[ra] == PEND_W'(1) && whit[ra]);
            end
        end

        assign bus.rdata[i*DATA_W +: DATA_W] = rd;
        assign bus.rbusy[i]                  = busy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb
// Directed-vector bench for regfile_sb with default parameters (BYPASS=1).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// checked before the next edge, registered ones 1 unit after it.

module tb_regfile_sb;

    logic clk;
    logic rst;

    regfile_sb_if bus ();

    regfile_sb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checkCount = 0;
    int passCount  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            passCount++;
        end
    endtask

    task automatic applyStimulus(
        input logic [1:0]  we,
        input logic [4:0]  wa0, input logic [31:0] wd0,
        input logic [4:0]  wa1, input logic [31:0] wd1,
        input logic [1:0]  re,
        input logic [4:0]  ra0, input logic [4:0] ra1,
        input logic        rsvEn, input logic [4:0] rsvAddr,
        input logic        flush
    );
        bus.we       = we;
        bus.waddr    = {wa1, wa0};
        bus.wdata    = {wd1, wd0};
        bus.re       = re;
        bus.raddr    = {ra1, ra0};
        bus.rsv_en   = rsvEn;
        bus.rsv_addr = rsvAddr;
        bus.flush    = flush;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rd0();
        return bus.rdata[31:0];
    endfunction

    function automatic logic [31:0] rd1();
        return bus.rdata[63:32];
    endfunction

    initial begin
        rst = 1'b1;
        applyStimulus(2'b11, 5'd1, 32'h1, 5'd2, 32'h2, 2'b11, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0);
        checkOutput("rst_rdata0", rd0(), 32'h0);
        checkOutput("rst_rdata1", rd1(), 32'h0);
        checkOutput("rst_rsv_ok", {31'b0, bus.rsv_ok}, 32'h0);
        checkOutput("rst_rbusy", {30'b0, bus.rbusy}, 32'h0);
        checkOutput("rst_conflict", {31'b0, bus.wr_conflict}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Preload r1/r2, then reset asynchronously mid-cycle.
        applyStimulus(2'b11, 5'd1, 32'h1111, 5'd2, 32'h2222, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
        checkOutput("preload_r1", rd0(), 32'h1111);
        checkOutput("preload_r2", rd1(), 32'h2222);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_rdata0", rd0(), 32'h0);
        checkOutput("async_rst_rdata1", rd1(), 32'h0);
        step();
        rst = 1'b0;
        for (int r = 1; r < 32; r++) begin
            applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'(r), 5'(r), 1'b0, 5'd0, 1'b0);
            checkOutput($sformatf("post_rst_r%0d", r), rd0(), 32'h0);
            checkOutput($sformatf("post_rst_busy_r%0d", r), {30'b0, bus.rbusy}, 32'h0);
        end

        // Bypass: write r5 on port 0, read it on port 1 in the same cycle.
        applyStimulus(2'b01, 5'd5, 32'hA, 5'd0, 32'h0, 2'b10, 5'd0, 5'd5, 1'b0, 5'd0, 1'b0);
        checkOutput("bypass_r5", rd1(), 32'hA);
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0);
        checkOutput("r5_port0", rd0(), 32'hA);
        checkOutput("r5_port1", rd1(), 32'hA);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0);
        checkOutput("re0_gates_data", rd0(), 32'h0);

        // Two ports writing r7: port 1 wins, conflict pulses for one cycle.
        applyStimulus(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 2'b01, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("bypass_r7_prio", rd0(), 32'h22);
        checkOutput("conflict_pre", {31'b0, bus.wr_conflict}, 32'h0);
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("r7_prio", rd0(), 32'h22);
        checkOutput("conflict_pulse", {31'b0, bus.wr_conflict}, 32'h1);
        applyStimulus(2'b11, 5'd0, 32'h5, 5'd0, 32'h6, 2'b01, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        checkOutput("r0_reads_zero", rd0(), 32'h0);
        checkOutput("rsv_r0_rejected", {31'b0, bus.rsv_ok}, 32'h0);
        step();
        checkOutput("conflict_one_cycle", {31'b0, bus.wr_conflict}, 32'h0);

        // Reserve r3 to saturation, then drain with three write-backs.
        for (int n = 0; n < 3; n++) begin
            applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0);
            checkOutput($sformatf("rsv_r3_%0d", n), {31'b0, bus.rsv_ok}, 32'h1);
            step();
        end
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd3, 5'd0, 1'b1, 5'd3, 1'b0);
        checkOutput("rsv_r3_full", {31'b0, bus.rsv_ok}, 32'h0);
        checkOutput("r3_busy_full", {31'b0, bus.rbusy[0]}, 32'h1);
        step();
        applyStimulus(2'b01, 5'd3, 32'h33, 5'd0, 32'h0, 2'b10, 5'd0, 5'd3, 1'b0, 5'd0, 1'b0);
        checkOutput("r3_busy_wb1", {31'b0, bus.rbusy[1]}, 32'h1);
        step();
        applyStimulus(2'b01, 5'd3, 32'h34, 5'd0, 32'h0, 2'b10, 5'd0, 5'd3, 1'b0, 5'd0, 1'b0);
        checkOutput("r3_busy_wb2", {31'b0, bus.rbusy[1]}, 32'h1);
        step();
        applyStimulus(2'b01, 5'd3, 32'h35, 5'd0, 32'h0, 2'b10, 5'd0, 5'd3, 1'b0, 5'd0, 1'b0);
        checkOutput("r3_busy_wb3_bypass", {31'b0, bus.rbusy[1]}, 32'h0);
        checkOutput("r3_data_wb3_bypass", rd1(), 32'h35);
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("r3_idle_busy", {31'b0, bus.rbusy[0]}, 32'h0);
        checkOutput("r3_idle_data", rd0(), 32'h35);

        // Reserve and write r9 in one cycle with one write pending.
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0);
        step();
        applyStimulus(2'b10, 5'd0, 32'h0, 5'd9, 32'h99, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0);
        checkOutput("rsv_r9_with_wb", {31'b0, bus.rsv_ok}, 32'h1);
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("r9_still_busy", {31'b0, bus.rbusy[0]}, 32'h1);
        checkOutput("r9_data", rd0(), 32'h99);
        applyStimulus(2'b01, 5'd9, 32'h9A, 5'd0, 32'h0, 2'b10, 5'd0, 5'd9, 1'b0, 5'd0, 1'b0);
        checkOutput("r9_last_wb_bypass", {31'b0, bus.rbusy[1]}, 32'h0);
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("r9_drained", {31'b0, bus.rbusy[0]}, 32'h0);

        // Flush with pending r4/r6 and a concurrent write to r4.
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0);
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd6, 1'b0);
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd4, 5'd6, 1'b0, 5'd0, 1'b0);
        checkOutput("r4_busy_pre_flush", {31'b0, bus.rbusy[0]}, 32'h1);
        checkOutput("r6_busy_pre_flush", {31'b0, bus.rbusy[1]}, 32'h1);
        applyStimulus(2'b01, 5'd4, 32'h5, 5'd0, 32'h0, 2'b11, 5'd4, 5'd6, 1'b1, 5'd10, 1'b1);
        checkOutput("rsv_during_flush", {31'b0, bus.rsv_ok}, 32'h0);
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd4, 5'd6, 1'b0, 5'd0, 1'b0);
        checkOutput("r4_busy_post_flush", {31'b0, bus.rbusy[0]}, 32'h0);
        checkOutput("r6_busy_post_flush", {31'b0, bus.rbusy[1]}, 32'h0);
        checkOutput("r4_data_post_flush", rd0(), 32'h5);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd10, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("r10_not_reserved", {31'b0, bus.rbusy[0]}, 32'h0);
        applyStimulus(2'b10, 5'd0, 32'h0, 5'd6, 32'h66, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd6, 1'b1, 5'd6, 1'b0);
        checkOutput("r6_late_wb_busy", {31'b0, bus.rbusy[1]}, 32'h0);
        checkOutput("r6_late_wb_data", rd1(), 32'h66);
        checkOutput("r6_rsv_after_floor", {31'b0, bus.rsv_ok}, 32'h1);
        step();
        applyStimulus(2'b01, 5'd6, 32'h67, 5'd0, 32'h0, 2'b01, 5'd6, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("r6_busy_after_rsv", {31'b0, bus.rbusy[0]}, 32'h0);
        step();
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd6, 5'd0, 1'b0, 5'd0, 1'b0);
        checkOutput("r6_drained", {31'b0, bus.rbusy[0]}, 32'h0);
        checkOutput("r6_final_data", rd0(), 32'h67);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port general-purpose register file with write-through bypass and an in-flight write scoreboard, the next-generation replacement for the two-read/one-write `regfile` in the five-stage pipeline. Decode/issue reads operands through NUM_RD ports and reserves destination registers. Write-back retires them through NUM_WR ports. Per-register pending counters tell issue logic when an operand is not yet produced.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, address width; register count NREG = 2**ADDR_W
- NUM_RD, 2, read ports
- NUM_WR, 2, write ports
- PEND_W, 2, pending-counter width; max in-flight writes per register = 2**PEND_W-1
- BYPASS, 1, 1 = same-cycle write data forwarded to reads

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset (`RstEnable` = 1)
- we  in  NUM_WR  write enables
- waddr  in  NUM_WR*ADDR_W  write addresses, port k at [k*ADDR_W +: ADDR_W]
- wdata  in  NUM_WR*DATA_W  write data
- re  in  NUM_RD  read enables
- raddr  in  NUM_RD*ADDR_W  read addresses
- rdata  out  NUM_RD*DATA_W  read data, combinational
- rbusy  out  NUM_RD  operand still pending, combinational
- rsv_en  in  1  reserve a destination (issue)
- rsv_addr  in  ADDR_W  destination to reserve
- rsv_ok  out  1  reservation accepted, combinational
- flush  in  1  synchronous clear of all pending counters
- wr_conflict  out  1  registered; pulses one cycle after two enabled write ports hit the same non-zero address

## Operation
- Register 0:
  - Never written.
  - Never reserved; rsv_ok=0 for addr 0.
  - Reads 0.
  - rbusy=0.
- Writes:
  - On a clock edge, regs[waddr_k] <= wdata_k for each enabled port with non-zero address.
  - Same address on several ports: highest port index wins.
  - wr_conflict=1 next cycle.
- Read port i, in priority order:
  - rst=1 -> rdata=0.
  - raddr=0 -> rdata=0.
  - re=0 -> rdata=0.
  - BYPASS and some enabled write port matches -> wdata of highest matching port.
  - Otherwise -> regs[raddr].
- Pending counter cnt[r], per register:
  - +1 on accepted reservation.
  - -1 when at least one enabled write targets r with cnt[r]>0. Multiple writes to r in one cycle decrement once.
  - Write to r with cnt[r]=0 leaves cnt at 0.
  - Accepted reserve and write to the same r in one cycle: cnt unchanged.
- rsv_ok = rsv_en & rsv_addr≠0 & (cnt[rsv_addr] < max, or a write to rsv_addr this cycle).
  - Rejected reservation: no state change. Issue must stall.
- rbusy[i] = re[i] & raddr≠0 & cnt[raddr]≠0. The BYPASS=1 exception: 0 if cnt[raddr]=1 and a write to raddr is present this cycle.
- flush=1: all cnt <= 0 at the edge, overriding reserve/decrement. Register data writes still occur. rsv_ok is forced to 0 during flush.

## Timing
- Reset (async assert, registers cleared immediately):
  - All regs = 0.
  - All cnt = 0.
  - wr_conflict = 0.
  - rdata = 0, rbusy = 0, rsv_ok = 0 while rst=1.
- Read latency: 0 cycles, combinational from raddr/re/we/waddr/wdata.
- Write latency: visible in the array after 1 edge; visible the same cycle via bypass when BYPASS=1.
- Reserve-to-busy: rbusy asserts the cycle after rsv accepted.
- Reset mid-operation: all pending state lost; in-flight write-backs after reset decrement nothing (cnt=0 floor).
- Counter never wraps: saturation is prevented by rsv_ok.

## Structure
- Shared constants stay in `defines.v`: `RegBus`, `RegAddrBus`, `RegNum`, `RegNumLog2`, `RstEnable`, `WriteEnable`, `ReadEnable`, `ZeroWord`. Add `PendBus` for the counter width.
- Sub-module `regfile_sb_cnt`: one pending counter with inc/dec/flush/sat logic, instantiated NREG-1 times via generate (none for register 0).
- Read ports and write-priority mux built with generate loops over NUM_RD/NUM_WR.

## Test plan
- Reset with regs preloaded, assert rst mid-cycle -> all rdata=0 immediately; after release, read r1..r31 -> all 0, rbusy=0.
- Write r5=0x0000000A on port 0, same cycle read r5 on port 1 -> rdata=0x0000000A (BYPASS=1), 0 (BYPASS=0); next cycle both -> 0x0000000A.
- Ports 0 and 1 write r7 with 0x11 and 0x22 in one cycle -> r7=0x22, wr_conflict=1 for exactly one cycle.
- Reserve r3 three times -> rsv_ok=1 each time. Fourth attempt -> rsv_ok=0. Three write-backs to r3 -> rbusy drops after the third; same-cycle read of that write shows rbusy=0.
- Reserve r9 and write r9 in the same cycle with cnt=1 -> cnt stays 1, rbusy=1 next cycle.
- Reserve r4 and r6, then flush with a concurrent write r4=0x5 -> next cycle rbusy=0 for both, r4 reads 0x5, later write to r6 leaves cnt=0.
